// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of a 5-stage MIPS pipeline.
// It holds PC_F, issues instruction-memory requests and drives the IF/ID
// register (IR_D, pc4_D, valid_D). Taken branches and jumps keep their
// delay slot. A one-entry skid buffer covers hazard stalls, and flush
// redirects fetch for exceptions and ERET.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   stall                hazard unit holds D and PC_F
//   take_D, npc          taken-redirect strobe (qualified by valid_D) and target
//   flush, flush_pc      exception/ERET redirect, highest priority
//   imem_ack, imem_rdata instruction memory response for imem_addr this cycle
//   imem_req, imem_addr  fetch request; the address equals PC_F
//   PC_F                 current fetch PC
//   IR_D, pc4_D, valid_D IF/ID pipeline register
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        take_D,
    input  logic [31:0] npc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] PC_F,
    output logic [31:0] IR_D,
    output logic [31:0] pc4_D,
    output logic        valid_D
);

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_BUF   = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   buf_q, buf_d;
    logic              redir_pend_q, redir_pend_d;
    logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
    logic [XLEN-1:0]   ir_q, ir_d;
    logic [XLEN-1:0]   pc4_q, pc4_d;
    logic              valid_q, valid_d;

    logic              fetch_ok;
    logic              redirect;
    logic [XLEN-1:0]   inst_f;
    logic [XLEN-1:0]   pc_plus4;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            buf_q        <= '0;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= '0;
            ir_q         <= '0;
            pc4_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_q        <= buf_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
            ir_q         <= ir_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
        end
    end

    // Next-state logic, in priority order: flush, stall, deliver, bubble
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_d        = buf_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        ir_d         = ir_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;

        fetch_ok = (state_q == ST_BUF) || imem_ack;
        inst_f   = (state_q == ST_BUF) ? buf_q : imem_rdata;
        redirect = valid_q & take_D & ~stall;
        pc_plus4 = pc_q + XLEN'(4);

        if (flush) begin
            pc_d         = flush_pc;
            ir_d         = '0;
            pc4_d        = '0;
            valid_d      = 1'b0;
            redir_pend_d = 1'b0;
            state_d      = ST_FETCH;
        end else if (stall) begin
            // Park a word that arrives during a stall so the memory can move on
            if (state_q == ST_FETCH && imem_ack) begin
                buf_d   = imem_rdata;
                state_d = ST_BUF;
            end
        end else if (fetch_ok) begin
            ir_d         = inst_f;
            pc4_d        = pc_plus4;
            valid_d      = 1'b1;
            state_d      = ST_FETCH;
            redir_pend_d = 1'b0;
            // The word delivered now is the delay slot when a redirect applies
            if (redirect) begin
                pc_d = npc;
            end else if (redir_pend_q) begin
                pc_d = redir_pc_q;
            end else begin
                pc_d = pc_plus4;
            end
        end else begin
            ir_d    = '0;
            valid_d = 1'b0;
            // Delay slot is still unfetched at PC_F; remember the target
            if (redirect) begin
                redir_pend_d = 1'b1;
                redir_pc_d   = npc;
            end
        end
    end

    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign PC_F      = pc_q;
    assign IR_D      = ir_q;
    assign pc4_D     = pc4_q;
    assign valid_D   = valid_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: holds PC_F, issues instruction-memory requests, and drives the IF/ID pipeline register (IR_D, pc4_D, valid_D) that the next-PC logic and decoder consume. It takes the next-PC value computed in D together with a taken-redirect strobe and applies MIPS branch-delay-slot semantics. Handles memory wait cycles, hazard stalls (via a one-entry skid buffer) and exception/ERET flush.

## Interface
- RESET_PC, 32'h0000_3000, PC_F value after reset.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- stall  in  1  hazard unit: hold D, hold PC_F.
- take_D  in  1  D instruction is a taken branch/jump; qualified by valid_D.
- npc  in  32  target from next-PC logic, valid while take_D=1.
- flush  in  1  exception/ERET redirect, highest priority.
- flush_pc  in  32  redirect address when flush=1.
- imem_ack  in  1  imem_rdata valid for imem_addr this cycle.
- imem_rdata  in  32  instruction word.
- imem_req  out  1  fetch request for imem_addr.
- imem_addr  out  32  equals PC_F.
- PC_F  out  32  current fetch PC.
- IR_D  out  32  instruction in D (0 = nop when bubble).
- pc4_D  out  32  PC of D instruction + 4.
- valid_D  out  1  IR_D holds a real instruction.

## Operation
- State: PC_F, FSM {FETCH, BUF}, buf[31:0], redir_pend, redir_pc[31:0], IR_D, pc4_D, valid_D.
- imem_req = (state==FETCH); imem_addr = PC_F. Address may change any cycle; ack qualifies only the current cycle.
- fetch_ok = (FETCH & imem_ack) | BUF; inst_F = BUF ? buf : imem_rdata.
- redirect event: valid_D & take_D & !stall.
- Per cycle, priority order:
  - flush: PC_F<=flush_pc; IR_D<=0, valid_D<=0, pc4_D<=0; redir_pend<=0; state<=FETCH (buffer discarded).
  - stall & fetch_ok: D, PC_F hold; if FETCH, buf<=imem_rdata, state<=BUF; if BUF, stay.
  - stall & !fetch_ok: everything holds.
  - !stall & fetch_ok: IR_D<=inst_F, pc4_D<=PC_F+4, valid_D<=1, state<=FETCH. PC_F <= redirect event ? npc : redir_pend ? redir_pc : PC_F+4. Clear redir_pend. The instruction delivered here is the delay slot when a redirect applies.
  - !stall & !fetch_ok: bubble: IR_D<=0, valid_D<=0, pc4_D holds; PC_F holds. If redirect event, redir_pend<=1, redir_pc<=npc (delay slot still unfetched at PC_F).
- take_D ignored when valid_D=0 or stall=1 (stalled D retains branch and re-presents it).
- Redirect event while redir_pend=1 cannot occur (D is bubble); no handling required beyond npc precedence.
- PC arithmetic modulo 2^32; PC_F+4 wraps 0xFFFF_FFFC -> 0x0000_0000. No alignment check.

## Timing
- Reset (async, immediate): PC_F=RESET_PC, state=FETCH, imem_req=1, imem_addr=RESET_PC, IR_D=0, pc4_D=0, valid_D=0, buf=0, redir_pend=0, redir_pc=0.
- Fetch-to-D latency: 1 cycle after ack with no stall; zero-wait memory sustains one instruction/cycle.
- Taken branch in D: target address on imem_addr the cycle after the delay slot enters D; no fetch cycle lost when ack=1.
- BUF: imem_req=0; buffered instruction enters D on first cycle with stall=0.
- flush takes effect at the next edge regardless of stall, ack, BUF or redir_pend.
- Deasserting reset mid-request: first request at RESET_PC on the following cycle.

## Test plan
- Reset, ack=1, stall=0: imem_addr 0x3000,0x3004,0x3008 on successive cycles; IR_D follows one cycle later with pc4_D 0x3004,0x3008,0x300C, valid_D=1.
- Branch in D (pc4_D=0x300C), take_D=1, npc=0x3100, ack=1: next cycle IR_D=word@0x300C, imem_addr=0x3100.
- Same branch with ack=0 for 2 cycles: valid_D=0 bubbles, imem_addr stays 0x300C; on ack, delay slot enters D, then imem_addr=0x3100.
- ack=1 with stall=1 for 3 cycles: imem_req drops, IR_D held; on release the buffered word enters D, imem_addr advances by 4 once.
- flush=1, flush_pc=0x4180 while in BUF with redir_pend=1: next cycle imem_addr=0x4180, IR_D=0, valid_D=0, pending redirect discarded.
- Assert reset mid-stream with valid_D=1: outputs return to reset values without a clock edge.
